// File: rtl/usb_rx_deserializer_if.sv
// Line-side inputs and byte/framing outputs of the USB receive front end.
// master = deserializer, slave = line driver / packet consumer.
interface usb_rx_deserializer_if;
    logic       iDP;
    logic       iDM;
    logic       iIS_FS;
    logic       iEN;
    logic [7:0] oBYTE;
    logic       oBYTE_VLD;
    logic       oSOP;
    logic       oEOP;
    logic       oERR;
    logic       oACTIVE;

    modport master (
        input  iDP, iDM, iIS_FS, iEN,
        output oBYTE, oBYTE_VLD, oSOP, oEOP, oERR, oACTIVE
    );

    modport slave (
        output iDP, iDM, iIS_FS, iEN,
        input  oBYTE, oBYTE_VLD, oSOP, oEOP, oERR, oACTIVE
    );
endinterface

// File: rtl/usb_rx_deserializer.sv
// USB receive front end: line synchronizer, mid-bit clock recovery, NRZI decode,
// SYNC/EOP framing, bit unstuffing and LSB-first byte assembly.
module usb_rx_deserializer #(
    parameter int LS_DIV       = 32,
    parameter int FS_DIV       = 4,
    parameter int SYNC_TIMEOUT = 16
) (
    input  logic                  iCLK,
    input  logic                  iRSTN,
    usb_rx_deserializer_if.master bus
);
    localparam int MAX_DIV = (LS_DIV > FS_DIV) ? LS_DIV : FS_DIV;
    localparam int PH_W    = $clog2(MAX_DIV);
    localparam int TO_W    = $clog2(SYNC_TIMEOUT + 1);

    localparam logic [PH_W-1:0] LS_HALF = PH_W'(LS_DIV / 2);
    localparam logic [PH_W-1:0] LS_LAST = PH_W'(LS_DIV - 1);
    localparam logic [PH_W-1:0] FS_HALF = PH_W'(FS_DIV / 2);
    localparam logic [PH_W-1:0] FS_LAST = PH_W'(FS_DIV - 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(SYNC_TIMEOUT - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SYNC,
        ST_DATA,
        ST_EOP,
        ST_ABORT
    } state_t;

    state_t          state_reg, state_next;
    logic [1:0]      line_raw;
    logic [1:0]      line_sync;
    logic [1:0]      line_hist_reg;
    logic [PH_W-1:0] phase_reg, phase_next;
    logic            fs_reg, fs_next;
    logic            prev_k_reg, prev_k_next;
    logic [2:0]      zero_cnt_reg, zero_cnt_next;
    logic [2:0]      ones_cnt_reg, ones_cnt_next;
    logic [2:0]      bit_cnt_reg, bit_cnt_next;
    logic [6:0]      shift_reg, shift_next;
    logic [TO_W-1:0] sync_cnt_reg, sync_cnt_next;
    logic            partial_reg, partial_next;
    logic            abort_se0_reg, abort_se0_next;
    logic [7:0]      byte_reg, byte_next;
    logic            vld_reg, vld_next;
    logic            sop_reg, sop_next;
    logic            eop_reg, eop_next;
    logic            err_reg, err_next;

    logic            mode_fs;
    logic [PH_W-1:0] div_half;
    logic [PH_W-1:0] div_last;
    logic            se0;
    logic            lvl_k;
    logic            is_j;
    logic            is_k;
    logic            dec_one;
    logic            tick;

    assign line_raw = {bus.iDP, bus.iDM};

    // Two-flop synchronizer per line; bit 1 = D+, bit 0 = D-.
    for (genvar gi = 0; gi < 2; gi++) begin : g_sync
        logic meta_reg;
        logic sync_reg;
        always_ff @(posedge iCLK or negedge iRSTN) begin
            if (!iRSTN) begin
                meta_reg <= 1'b0;
                sync_reg <= 1'b0;
            end else begin
                meta_reg <= line_raw[gi];
                sync_reg <= meta_reg;
            end
        end
        assign line_sync[gi] = sync_reg;
    end

    // Speed follows the input while idle and is frozen for the whole packet.
    assign mode_fs  = (state_reg == ST_IDLE) ? bus.iIS_FS : fs_reg;
    assign div_half = mode_fs ? FS_HALF : LS_HALF;
    assign div_last = mode_fs ? FS_LAST : LS_LAST;
    assign se0      = ~line_sync[1] & ~line_sync[0];
    assign lvl_k    = mode_fs ? line_sync[0] : line_sync[1];
    assign is_k     = lvl_k;
    assign is_j     = ~se0 & ~lvl_k;
    assign dec_one  = (lvl_k == prev_k_reg);

    always_comb begin
        tick       = 1'b0;
        phase_next = phase_reg - PH_W'(1);
        if (line_sync != line_hist_reg) begin
            phase_next = div_half;
        end else if (phase_reg == '0) begin
            tick       = 1'b1;
            phase_next = div_last;
        end
    end

    always_comb begin
        state_next     = state_reg;
        fs_next        = fs_reg;
        prev_k_next    = prev_k_reg;
        zero_cnt_next  = zero_cnt_reg;
        ones_cnt_next  = ones_cnt_reg;
        bit_cnt_next   = bit_cnt_reg;
        shift_next     = shift_reg;
        sync_cnt_next  = sync_cnt_reg;
        partial_next   = partial_reg;
        abort_se0_next = abort_se0_reg;
        byte_next      = byte_reg;
        vld_next       = 1'b0;
        sop_next       = 1'b0;
        eop_next       = 1'b0;
        err_next       = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                if (tick && is_k) begin
                    state_next    = ST_SYNC;
                    fs_next       = bus.iIS_FS;
                    prev_k_next   = 1'b0;
                    zero_cnt_next = '0;
                    sync_cnt_next = '0;
                end
            end
            ST_SYNC: begin
                if (tick) begin
                    prev_k_next = lvl_k;
                    if (se0) begin
                        state_next = ST_IDLE;
                    end else if (dec_one && zero_cnt_reg >= 3'd5) begin
                        state_next    = ST_DATA;
                        sop_next      = 1'b1;
                        ones_cnt_next = '0;
                        bit_cnt_next  = '0;
                        shift_next    = '0;
                    end else begin
                        if (dec_one) begin
                            zero_cnt_next = '0;
                        end else if (zero_cnt_reg != 3'd7) begin
                            zero_cnt_next = zero_cnt_reg + 3'd1;
                        end
                        if (sync_cnt_reg == TO_LAST) begin
                            err_next   = 1'b1;
                            state_next = ST_IDLE;
                        end else begin
                            sync_cnt_next = sync_cnt_reg + TO_W'(1);
                        end
                    end
                end
            end
            ST_DATA: begin
                if (tick) begin
                    prev_k_next = lvl_k;
                    if (se0) begin
                        state_next   = ST_EOP;
                        partial_next = (bit_cnt_reg != 3'd0);
                    end else if (ones_cnt_reg == 3'd6) begin
                        // Bit after six ones is a stuff bit: must be a zero.
                        if (dec_one) begin
                            err_next       = 1'b1;
                            state_next     = ST_ABORT;
                            abort_se0_next = 1'b0;
                        end else begin
                            ones_cnt_next = '0;
                        end
                    end else begin
                        shift_next    = {dec_one, shift_reg[6:1]};
                        ones_cnt_next = dec_one ? ones_cnt_reg + 3'd1 : 3'd0;
                        bit_cnt_next  = bit_cnt_reg + 3'd1;
                        if (bit_cnt_reg == 3'd7) begin
                            byte_next = {dec_one, shift_reg};
                            vld_next  = 1'b1;
                        end
                    end
                end
            end
            ST_EOP: begin
                if (tick) begin
                    if (is_j) begin
                        eop_next   = 1'b1;
                        err_next   = partial_reg;
                        state_next = ST_IDLE;
                    end else if (is_k) begin
                        err_next       = 1'b1;
                        state_next     = ST_ABORT;
                        abort_se0_next = 1'b0;
                    end
                end
            end
            ST_ABORT: begin
                if (tick) begin
                    if (se0) begin
                        abort_se0_next = 1'b1;
                    end else if (is_j && abort_se0_reg) begin
                        state_next = ST_IDLE;
                    end
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase

        if (!bus.iEN) begin
            state_next = ST_IDLE;
            byte_next  = byte_reg;
            vld_next   = 1'b0;
            sop_next   = 1'b0;
            eop_next   = 1'b0;
            err_next   = 1'b0;
        end
    end

    always_ff @(posedge iCLK or negedge iRSTN) begin
        if (!iRSTN) begin
            state_reg     <= ST_IDLE;
            line_hist_reg <= '0;
            phase_reg     <= '0;
            fs_reg        <= 1'b0;
            prev_k_reg    <= 1'b0;
            zero_cnt_reg  <= '0;
            ones_cnt_reg  <= '0;
            bit_cnt_reg   <= '0;
            shift_reg     <= '0;
            sync_cnt_reg  <= '0;
            partial_reg   <= 1'b0;
            abort_se0_reg <= 1'b0;
            byte_reg      <= '0;
            vld_reg       <= 1'b0;
            sop_reg       <= 1'b0;
            eop_reg       <= 1'b0;
            err_reg       <= 1'b0;
        end else begin
            state_reg     <= state_next;
            line_hist_reg <= line_sync;
            phase_reg     <= phase_next;
            fs_reg        <= fs_next;
            prev_k_reg    <= prev_k_next;
            zero_cnt_reg  <= zero_cnt_next;
            ones_cnt_reg  <= ones_cnt_next;
            bit_cnt_reg   <= bit_cnt_next;
            shift_reg     <= shift_next;
            sync_cnt_reg  <= sync_cnt_next;
            partial_reg   <= partial_next;
            abort_se0_reg <= abort_se0_next;
            byte_reg      <= byte_next;
            vld_reg       <= vld_next;
            sop_reg       <= sop_next;
            eop_reg       <= eop_next;
            err_reg       <= err_next;
        end
    end

    assign bus.oBYTE     = byte_reg;
    assign bus.oBYTE_VLD = vld_reg;
    assign bus.oSOP      = sop_reg;
    assign bus.oEOP      = eop_reg;
    assign bus.oERR      = err_reg;
    assign bus.oACTIVE   = (state_reg != ST_IDLE);
endmodule

// File: tb/tb_usb_rx_deserializer.sv
// Scoreboard bench: packets are described as bytes/bits, encoded onto the line,
// and the expected strobe sequence is queued for an independent monitor.
module tb_usb_rx_deserializer;
    localparam int LS_DIV       = 32;
    localparam int FS_DIV       = 4;
    localparam int SYNC_TIMEOUT = 16;
    localparam int SYM_J        = 0;
    localparam int SYM_K        = 1;
    localparam int SYM_SE0      = 2;

    typedef struct {
        logic       sop;
        logic       vld;
        logic       eop;
        logic       err;
        logic       active;
        logic [7:0] data;
    } ev_t;

    logic iCLK  = 1'b0;
    logic iRSTN = 1'b0;
    bit   speed_fs = 1'b0;
    int   checks = 0;
    int   errors = 0;

    ev_t        exp_q[$];
    ev_t        exp_ev;
    int         line_q[$];
    bit         bits_q[$];
    logic [7:0] pay_q[$];

    always #10 iCLK = ~iCLK;

    usb_rx_deserializer_if bus();

    usb_rx_deserializer #(
        .LS_DIV      (LS_DIV),
        .FS_DIV      (FS_DIV),
        .SYNC_TIMEOUT(SYNC_TIMEOUT)
    ) dut (
        .iCLK (iCLK),
        .iRSTN(iRSTN),
        .bus  (bus)
    );

    function automatic ev_t mk_ev(input logic sop, input logic vld, input logic eop,
                                  input logic err, input logic active, input logic [7:0] data);
        ev_t e;
        e.sop = sop; e.vld = vld; e.eop = eop; e.err = err; e.active = active; e.data = data;
        return e;
    endfunction

    // Monitor: every strobe cycle must match the head of the expected queue.
    always @(negedge iCLK) begin
        if (bus.oSOP || bus.oBYTE_VLD || bus.oEOP || bus.oERR) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_event: got sop=%0b vld=%0b eop=%0b err=%0b byte=%02h, required no event",
                         bus.oSOP, bus.oBYTE_VLD, bus.oEOP, bus.oERR, bus.oBYTE);
            end else begin
                exp_ev = exp_q.pop_front();
                if (bus.oSOP !== exp_ev.sop || bus.oBYTE_VLD !== exp_ev.vld || bus.oEOP !== exp_ev.eop ||
                    bus.oERR !== exp_ev.err || bus.oACTIVE !== exp_ev.active ||
                    (exp_ev.vld && bus.oBYTE !== exp_ev.data)) begin
                    errors++;
                    $display("FAIL event: got sop=%0b vld=%0b eop=%0b err=%0b act=%0b byte=%02h, required sop=%0b vld=%0b eop=%0b err=%0b act=%0b byte=%02h",
                             bus.oSOP, bus.oBYTE_VLD, bus.oEOP, bus.oERR, bus.oACTIVE, bus.oBYTE,
                             exp_ev.sop, exp_ev.vld, exp_ev.eop, exp_ev.err, exp_ev.active, exp_ev.data);
                end else begin
                    $display("event ok: sop=%0b vld=%0b eop=%0b err=%0b byte=%02h",
                             bus.oSOP, bus.oBYTE_VLD, bus.oEOP, bus.oERR, bus.oBYTE);
                end
            end
        end
    end

    task automatic set_line(input int sym);
        logic k;
        k = (sym == SYM_K);
        if (sym == SYM_SE0) begin
            bus.iDP = 1'b0; bus.iDM = 1'b0;
        end else if (speed_fs) begin
            bus.iDP = ~k; bus.iDM = k;
        end else begin
            bus.iDP = k; bus.iDM = ~k;
        end
    endtask

    task automatic idle_bits(input int n);
        set_line(SYM_J);
        repeat (n * (speed_fs ? FS_DIV : LS_DIV)) @(posedge iCLK);
        #1;
    endtask

    task automatic add_bits(input logic [7:0] b, input int n);
        for (int i = 0; i < n; i++) bits_q.push_back(b[i]);
    endtask

    // SYNC, NRZI-encoded (optionally stuffed) bits_q, then SE0 SE0 J.
    task automatic build_line(input bit do_stuff);
        int sync_pat[8] = '{SYM_K, SYM_J, SYM_K, SYM_J, SYM_K, SYM_J, SYM_K, SYM_K};
        int lvl;
        int ones;
        line_q.delete();
        foreach (sync_pat[i]) line_q.push_back(sync_pat[i]);
        lvl  = SYM_K;
        ones = 0;
        foreach (bits_q[i]) begin
            if (!bits_q[i]) lvl = (lvl == SYM_K) ? SYM_J : SYM_K;
            line_q.push_back(lvl);
            if (bits_q[i]) begin
                ones++;
                if (do_stuff && ones == 6) begin
                    lvl = (lvl == SYM_K) ? SYM_J : SYM_K;
                    line_q.push_back(lvl);
                    ones = 0;
                end
            end else begin
                ones = 0;
            end
        end
        line_q.push_back(SYM_SE0);
        line_q.push_back(SYM_SE0);
        line_q.push_back(SYM_J);
    endtask

    task automatic drive_line(input int jit, input int nsym);
        int div, off_prev, off_cur, dur;
        div      = speed_fs ? FS_DIV : LS_DIV;
        off_prev = 0;
        for (int i = 0; i < nsym; i++) begin
            off_cur = (jit > 0 && i < nsym - 1) ? int'($urandom_range(2 * jit)) - jit : 0;
            dur     = div + off_cur - off_prev;
            set_line(line_q[i]);
            repeat (dur) @(posedge iCLK);
            #1;
            off_prev = off_cur;
        end
    endtask

    task automatic wait_drain(input string name, input int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(posedge iCLK);
            n++;
        end
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain_%s: %0d events outstanding, required 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic check_quiet(input string name);
        checks++;
        if ({bus.oBYTE, bus.oBYTE_VLD, bus.oSOP, bus.oEOP, bus.oERR, bus.oACTIVE} !== 13'd0) begin
            errors++;
            $display("FAIL %s: got byte=%02h vld=%0b sop=%0b eop=%0b err=%0b act=%0b, required all 0",
                     name, bus.oBYTE, bus.oBYTE_VLD, bus.oSOP, bus.oEOP, bus.oERR, bus.oACTIVE);
        end else begin
            $display("%s ok: outputs quiet", name);
        end
    endtask

    task automatic check_hold(input string name, input logic [7:0] exp_byte);
        checks++;
        if (bus.oBYTE !== exp_byte || bus.oACTIVE !== 1'b0) begin
            errors++;
            $display("FAIL hold_%s: got byte=%02h act=%0b, required byte=%02h act=0",
                     name, bus.oBYTE, bus.oACTIVE, exp_byte);
        end else begin
            $display("hold_%s ok: byte=%02h idle", name, bus.oBYTE);
        end
    endtask

    // Good packet from pay_q plus extra_n trailing bits of extra_v.
    task automatic run_good(input string name, input int extra_n, input logic [7:0] extra_v, input int jit);
        bits_q.delete();
        foreach (pay_q[i]) add_bits(pay_q[i], 8);
        if (extra_n > 0) add_bits(extra_v, extra_n);
        exp_q.push_back(mk_ev(1, 0, 0, 0, 1, 8'h00));
        foreach (pay_q[i]) exp_q.push_back(mk_ev(0, 1, 0, 0, 1, pay_q[i]));
        exp_q.push_back(mk_ev(0, 0, 1, extra_n != 0, 0, 8'h00));
        build_line(1'b1);
        drive_line(jit, line_q.size());
        idle_bits(6);
        wait_drain(name, 4000);
        check_hold(name, pay_q[pay_q.size() - 1]);
    endtask

    task automatic run_random(input int n, input int jit);
        int nb;
        int extra;
        for (int p = 0; p < n; p++) begin
            pay_q.delete();
            nb = int'($urandom_range(1, 3));
            for (int b = 0; b < nb; b++)
                pay_q.push_back(($urandom_range(1) == 0) ? 8'hFF : 8'($urandom));
            extra = ($urandom_range(2) == 0) ? int'($urandom_range(1, 7)) : 0;
            run_good($sformatf("rand%0d", p), extra, 8'($urandom), jit);
        end
    endtask

    initial begin
        bus.iEN    = 1'b1;
        bus.iIS_FS = 1'b0;
        set_line(SYM_J);
        repeat (5) @(posedge iCLK);
        #1;
        check_quiet("reset_state");
        iRSTN = 1'b1;
        idle_bits(4);

        // Low speed directed packets
        pay_q = {8'hC3, 8'h01};
        run_good("ls_basic", 0, 8'h00, 0);
        pay_q = {8'hFF, 8'h3F};
        run_good("ls_stuff", 0, 8'h00, 0);

        // Seven decoded ones right after SYNC
        bits_q.delete();
        repeat (7) bits_q.push_back(1'b1);
        bits_q.push_back(1'b0); bits_q.push_back(1'b1); bits_q.push_back(1'b0);
        exp_q.push_back(mk_ev(1, 0, 0, 0, 1, 8'h00));
        exp_q.push_back(mk_ev(0, 0, 0, 1, 1, 8'h00));
        build_line(1'b0);
        drive_line(0, line_q.size());
        idle_bits(6);
        wait_drain("stuff_err", 4000);
        check_hold("stuff_err", 8'h3F);
        pay_q = {8'h12, 8'h34};
        run_good("after_err", 0, 8'h00, 0);

        pay_q = {8'hA5};
        run_good("partial", 4, 8'h06, 0);

        // Lone K then idle J: SYNC never completes
        line_q.delete();
        line_q.push_back(SYM_K);
        repeat (SYNC_TIMEOUT + 4) line_q.push_back(SYM_J);
        exp_q.push_back(mk_ev(0, 0, 0, 1, 0, 8'h00));
        drive_line(0, line_q.size());
        idle_bits(4);
        wait_drain("sync_timeout", 4000);

        run_random(3, 3);

        // Reset in the middle of a packet
        pay_q = {8'h5A, 8'h33};
        bits_q.delete();
        foreach (pay_q[i]) add_bits(pay_q[i], 8);
        exp_q.push_back(mk_ev(1, 0, 0, 0, 1, 8'h00));
        exp_q.push_back(mk_ev(0, 1, 0, 0, 1, 8'h5A));
        build_line(1'b1);
        drive_line(0, 20);
        wait_drain("pre_reset", 200);
        #5;
        iRSTN = 1'b0;
        #1;
        check_quiet("midpkt_reset");
        set_line(SYM_J);
        repeat (5) @(posedge iCLK);
        #1;
        iRSTN = 1'b1;
        idle_bits(4);
        pay_q = {8'h77};
        run_good("post_reset", 0, 8'h00, 0);

        // Switch to full speed with the receiver disabled
        bus.iEN    = 1'b0;
        speed_fs   = 1'b1;
        bus.iIS_FS = 1'b1;
        set_line(SYM_J);
        repeat (10) @(posedge iCLK);
        #1;
        bus.iEN = 1'b1;
        idle_bits(8);
        pay_q = {8'hC3, 8'h01};
        run_good("fs_basic", 0, 8'h00, 0);
        pay_q = {8'hFF, 8'h3F};
        run_good("fs_stuff", 0, 8'h00, 0);
        run_random(4, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
